shared_port_arbiter: RTL and testbench

SHARED_PORT_ARBITER -- requirements
Module: shared_port_arbiter

---
 rtl/shared_port_arbiter_pkg.sv | 18 +
 rtl/shared_port_arbiter_rr_pick.sv | 32 +++
 rtl/shared_port_arbiter.sv | 95 +++++++++
 tb/tb_shared_port_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shared_port_arbiter_pkg.sv
// Shared definitions for the shared-port burst arbiter: default sizes,
// FSM state type and the owner-index width rule.
package shared_port_arbiter_pkg;

    localparam int N_DEF     = 4;
    localparam int WIDTH_DEF = 2;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        LOCK = 1'b1
    } state_t;

    // Owner index width; never zero so a 1-bit index still exists for tiny N.
    function automatic int owner_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shared_port_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting index after the last
// winner, in circular order, as both a one-hot and an index.
module rr_pick
    import shared_port_arbiter_pkg::*;
#(
    parameter int N  = N_DEF,
    parameter int OW = owner_w(N_DEF)
) (
    input  logic [N-1:0]  req,
    input  logic [OW-1:0] last,
    output logic [N-1:0]  pick,
    output logic [OW-1:0] idx
);

    always_comb begin
        int   k;
        logic found;
        pick  = '0;
        idx   = '0;
        found = 1'b0;
        k     = 0;
        for (int i = 1; i <= N; i++) begin
            k = (int'(last) + i) % N;
            if (!found && req[k]) begin
                found   = 1'b1;
                pick[k] = 1'b1;
                idx     = OW'(k);
            end
        end
    end

endmodule

// File: rtl/shared_port_arbiter.sv
// N-way burst arbiter in front of a shared port: round-robin selection,
// lock until the owner's last beat, one-entry registered output stage.
module shared_port_arbiter
    import shared_port_arbiter_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int WIDTH  = WIDTH_DEF,
    localparam int OW    = owner_w(N)
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [N-1:0]             i_req,
    input  logic [N-1:0][WIDTH-1:0]  i_data,
    input  logic [N-1:0]             i_last,
    output logic [N-1:0]             o_grant,
    output logic                     o_valid,
    output logic [WIDTH-1:0]         o_data,
    output logic                     o_last,
    output logic [OW-1:0]            o_owner,
    input  logic                     i_ready,
    output logic                     o_busy
);

    state_t        state;
    logic [OW-1:0] owner;
    logic [OW-1:0] winner;
    logic [N-1:0]  pick;
    logic [OW-1:0] pick_idx;
    logic          can_take;
    logic          accept;
    logic          accept_last;

    rr_pick #(
        .N  (N),
        .OW (OW)
    ) u_rr_pick (
        .req  (i_req),
        .last (winner),
        .pick (pick),
        .idx  (pick_idx)
    );

    assign o_busy      = (state == LOCK);
    assign can_take    = !o_valid || i_ready;
    // Grant stays up under backpressure; only acceptance is held off.
    assign accept      = |(i_req & o_grant) && can_take;
    assign accept_last = accept && i_last[owner];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state   <= IDLE;
            owner   <= '0;
            winner  <= OW'(N - 1);
            o_grant <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|i_req) begin
                        state   <= LOCK;
                        owner   <= pick_idx;
                        o_grant <= pick;
                    end
                end
                LOCK: begin
                    if (accept_last) begin
                        state   <= IDLE;
                        winner  <= owner;
                        o_grant <= '0;
                    end
                end
                default: begin
                    state   <= IDLE;
                    o_grant <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_last  <= 1'b0;
            o_owner <= '0;
        end else if (accept) begin
            o_valid <= 1'b1;
            o_data  <= i_data[owner];
            o_last  <= i_last[owner];
            o_owner <= owner;
        end else if (i_ready) begin
            o_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_shared_port_arbiter.sv
// Bench for shared_port_arbiter: directed scenarios plus a randomized run
// against a protocol-level round-robin / scoreboard model.
module tb_shared_port_arbiter;

    localparam int N     = 4;
    localparam int WIDTH = 3;

    logic                    i_clk = 1'b0;
    logic                    i_rst;
    logic [N-1:0]            i_req;
    logic [N-1:0][WIDTH-1:0] i_data;
    logic [N-1:0]            i_last;
    logic [N-1:0]            o_grant;
    logic                    o_valid;
    logic [WIDTH-1:0]        o_data;
    logic                    o_last;
    logic [1:0]              o_owner;
    logic                    i_ready;
    logic                    o_busy;

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [1:0]       owner;
        logic [WIDTH-1:0] data;
        logic             last;
    } beat_t;

    beat_t sb[$];

    shared_port_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_req   (i_req),
        .i_data  (i_data),
        .i_last  (i_last),
        .o_grant (o_grant),
        .o_valid (o_valid),
        .o_data  (o_data),
        .o_last  (o_last),
        .o_owner (o_owner),
        .i_ready (i_ready),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    // Round-robin rule: first requesting index after the previous winner.
    function automatic int rr_ref(input logic [N-1:0] req, input int last_w);
        for (int off = 1; off <= N; off++) begin
            if (req[(last_w + off) % N]) return (last_w + off) % N;
        end
        return -1;
    endfunction

    task automatic do_reset;
        i_rst = 1'b0; i_req = '0; i_data = '0; i_last = '0; i_ready = 1'b1;
        tick;
        i_rst = 1'b1;
    endtask

    task automatic test_reset;
        i_rst = 1'b0; i_req = '0; i_data = '0; i_last = '0; i_ready = 1'b0;
        tick;
        tests++; if (o_grant !== 4'b0) begin fails++; $display("FAIL reset_grant: got %b want 0000", o_grant); end
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", o_valid); end
        tests++; if (o_data !== 3'd0) begin fails++; $display("FAIL reset_data: got %0d want 0", o_data); end
        tests++; if (o_last !== 1'b0) begin fails++; $display("FAIL reset_last: got %b want 0", o_last); end
        tests++; if (o_owner !== 2'd0) begin fails++; $display("FAIL reset_owner: got %0d want 0", o_owner); end
        tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        i_rst = 1'b1;
    endtask

    task automatic test_single_burst;
        do_reset;
        i_req = 4'b0001; i_data[0] = 3'd1; i_last = '0; i_ready = 1'b1;
        tick;
        tests++; if (o_grant !== 4'b0001) begin fails++; $display("FAIL single_grant_c1: got %b want 0001", o_grant); end
        tests++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin fails++; $display("FAIL single_state_c1: valid %b busy %b want 0 1", o_valid, o_busy); end
        tick;
        tests++; if (o_valid !== 1'b1 || o_data !== 3'd1 || o_last !== 1'b0) begin fails++; $display("FAIL single_beat1: valid %b data %0d last %b want 1 1 0", o_valid, o_data, o_last); end
        i_data[0] = 3'd2; i_last[0] = 1'b1;
        tick;
        tests++; if (o_valid !== 1'b1 || o_data !== 3'd2 || o_last !== 1'b1) begin fails++; $display("FAIL single_beat2: valid %b data %0d last %b want 1 2 1", o_valid, o_data, o_last); end
        tests++; if (o_busy !== 1'b0 || o_grant !== 4'b0) begin fails++; $display("FAIL single_release: busy %b grant %b want 0 0000", o_busy, o_grant); end
        i_req = '0; i_last = '0;
        tick;
        tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL single_drain: valid %b want 0", o_valid); end
    endtask

    task automatic test_round_robin;
        int got[5];
        int n;
        n = 0;
        do_reset;
        i_req = 4'b1111; i_last = 4'b1111; i_ready = 1'b1;
        for (int k = 0; k < N; k++) i_data[k] = 3'(k);
        for (int c = 0; c < 16; c++) begin
            tick;
            if (o_valid && n < 5) begin
                tests++; if (o_data !== 3'(o_owner)) begin fails++; $display("FAIL rr_data: got %0d want %0d", o_data, o_owner); end
                got[n] = int'(o_owner);
                n++;
            end
        end
        tests++;
        if (n != 5) begin
            fails++; $display("FAIL rr_count: got %0d beats want 5", n);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++; if (got[i] != i % N) begin fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, got[i], i % N); end
            end
        end
        i_req = '0; i_last = '0;
        tick;
    endtask

    task automatic test_lock;
        do_reset;
        i_ready = 1'b1; i_req = 4'b0011; i_last = 4'b0010;
        i_data[0] = 3'd1; i_data[1] = 3'd5;
        tick;
        tests++; if (o_grant !== 4'b0001) begin fails++; $display("FAIL lock_g1: got %b want 0001", o_grant); end
        tick;
        tests++; if (o_grant !== 4'b0001 || o_data !== 3'd1) begin fails++; $display("FAIL lock_g2: grant %b data %0d want 0001 1", o_grant, o_data); end
        i_req[0] = 1'b0;
        tick;
        tests++; if (o_grant !== 4'b0001 || o_busy !== 1'b1) begin fails++; $display("FAIL lock_drop: grant %b busy %b want 0001 1", o_grant, o_busy); end
        i_req[0] = 1'b1; i_data[0] = 3'd2;
        tick;
        tests++; if (o_grant !== 4'b0001 || o_data !== 3'd2) begin fails++; $display("FAIL lock_g4: grant %b data %0d want 0001 2", o_grant, o_data); end
        i_data[0] = 3'd3; i_last[0] = 1'b1;
        tick;
        tests++; if (o_grant !== 4'b0000 || o_data !== 3'd3 || o_last !== 1'b1 || o_owner !== 2'd0) begin fails++; $display("FAIL lock_end: grant %b data %0d last %b owner %0d want 0000 3 1 0", o_grant, o_data, o_last, o_owner); end
        i_req[0] = 1'b0;
        tick;
        tests++; if (o_grant !== 4'b0010) begin fails++; $display("FAIL lock_next: got %b want 0010", o_grant); end
        tick;
        tests++; if (o_owner !== 2'd1 || o_data !== 3'd5) begin fails++; $display("FAIL lock_next_beat: owner %0d data %0d want 1 5", o_owner, o_data); end
        i_req = '0; i_last = '0;
        tick;
    endtask

    task automatic test_backpressure;
        logic [WIDTH-1:0] outs[8];
        logic             lasts[8];
        logic [WIDTH-1:0] snap_d;
        logic             snap_l;
        logic [1:0]       snap_o;
        logic             acc;
        logic             hold;
        int b;
        int nout;
        b = 0; nout = 0;
        do_reset;
        for (int c = 0; c < 30; c++) begin
            i_ready   = !(c >= 4 && c < 8);
            i_req     = (b < 5) ? 4'b0100 : 4'b0000;
            i_data[2] = 3'(b + 1);
            i_last[2] = (b == 4);
            @(negedge i_clk);
            acc    = i_req[2] && o_grant[2] && (!o_valid || i_ready);
            hold   = o_valid && !i_ready;
            snap_d = o_data; snap_l = o_last; snap_o = o_owner;
            if (o_valid && i_ready && nout < 8) begin
                outs[nout] = o_data; lasts[nout] = o_last; nout++;
            end
            tick;
            if (acc) b++;
            if (hold) begin
                tests++; if (!o_valid || o_data !== snap_d || o_last !== snap_l || o_owner !== snap_o) begin fails++; $display("FAIL bp_hold: valid %b data %0d last %b owner %0d want 1 %0d %b %0d", o_valid, o_data, o_last, o_owner, snap_d, snap_l, snap_o); end
            end
        end
        tests++;
        if (nout != 5) begin
            fails++; $display("FAIL bp_count: got %0d beats want 5", nout);
        end else begin
            for (int i = 0; i < 5; i++) begin
                tests++; if (outs[i] !== 3'(i + 1) || lasts[i] !== (i == 4)) begin fails++; $display("FAIL bp_beat[%0d]: data %0d last %b want %0d %b", i, outs[i], lasts[i], i + 1, i == 4); end
            end
        end
        i_req = '0; i_last = '0; i_ready = 1'b1;
        tick;
    endtask

    task automatic test_reset_mid_burst;
        do_reset;
        i_req = 4'b0001; i_data[0] = 3'd5; i_last = '0; i_ready = 1'b0;
        tick;
        tick;
        tests++; if (o_valid !== 1'b1 || o_busy !== 1'b1) begin fails++; $display("FAIL rmb_pre: valid %b busy %b want 1 1", o_valid, o_busy); end
        #2 i_rst = 1'b0;
        #1;
        tests++; if (o_grant !== 4'b0 || o_busy !== 1'b0) begin fails++; $display("FAIL rmb_ctrl: grant %b busy %b want 0000 0", o_grant, o_busy); end
        tests++; if (o_valid !== 1'b0 || o_data !== 3'd0 || o_last !== 1'b0 || o_owner !== 2'd0) begin fails++; $display("FAIL rmb_out: valid %b data %0d last %b owner %0d want all 0", o_valid, o_data, o_last, o_owner); end
        tick;
        i_rst = 1'b1; i_req = 4'b1000; i_data[3] = 3'd6; i_last = 4'b1000; i_ready = 1'b1;
        tick;
        tests++; if (o_grant !== 4'b1000) begin fails++; $display("FAIL rmb_regrant: got %b want 1000", o_grant); end
        tick;
        tests++; if (o_valid !== 1'b1 || o_owner !== 2'd3 || o_data !== 3'd6) begin fails++; $display("FAIL rmb_beat: valid %b owner %0d data %0d want 1 3 6", o_valid, o_owner, o_data); end
        i_req = '0; i_last = '0;
        tick;
    endtask

    task automatic test_random;
        logic [N-1:0] g_pre;
        logic [N-1:0] req_pre;
        logic [N-1:0] exp_g;
        logic         acc_last;
        int           acc_own;
        int           ref_w;
        beat_t        bt;
        do_reset;
        sb.delete();
        ref_w = N - 1;
        for (int c = 0; c < 10004; c++) begin
            if (c < 10000) begin
                i_req = 4'($urandom);
                for (int k = 0; k < N; k++) begin
                    i_data[k] = 3'($urandom);
                    i_last[k] = ($urandom_range(0, 3) == 0);
                end
                i_ready = ($urandom_range(0, 3) != 0);
            end else begin
                i_req = '0; i_ready = 1'b1;
            end
            @(negedge i_clk);
            g_pre = o_grant; req_pre = i_req; acc_last = 1'b0; acc_own = 0;
            tests++;
            if (o_valid) begin
                if (sb.size() == 0) begin
                    fails++; $display("FAIL rand_extra: cycle %0d beat owner %0d data %0d with empty scoreboard", c, o_owner, o_data);
                end else begin
                    if (o_owner !== sb[0].owner || o_data !== sb[0].data || o_last !== sb[0].last) begin
                        fails++; $display("FAIL rand_beat: cycle %0d got o%0d d%0d l%b want o%0d d%0d l%b", c, o_owner, o_data, o_last, sb[0].owner, sb[0].data, sb[0].last);
                    end
                    if (i_ready) void'(sb.pop_front());
                end
            end else if (sb.size() != 0) begin
                fails++; $display("FAIL rand_lost: cycle %0d output idle with %0d pending beats", c, sb.size());
            end
            for (int k = 0; k < N; k++) begin
                if (i_req[k] && o_grant[k] && (!o_valid || i_ready)) begin
                    bt.owner = 2'(k); bt.data = i_data[k]; bt.last = i_last[k];
                    sb.push_back(bt);
                    if (i_last[k]) begin acc_last = 1'b1; acc_own = k; end
                end
            end
            tick;
            if (g_pre == '0) exp_g = (req_pre != '0) ? (4'b0001 << rr_ref(req_pre, ref_w)) : 4'b0000;
            else if (acc_last) begin exp_g = '0; ref_w = acc_own; end
            else exp_g = g_pre;
            tests++; if (o_grant !== exp_g) begin fails++; $display("FAIL rand_grant: cycle %0d got %b want %b", c, o_grant, exp_g); end
            tests++; if (o_busy !== (exp_g != '0)) begin fails++; $display("FAIL rand_busy: cycle %0d got %b want %b", c, o_busy, exp_g != '0); end
        end
        tests++; if (sb.size() != 0 || o_valid !== 1'b0) begin fails++; $display("FAIL rand_drain: pending %0d valid %b want 0 0", sb.size(), o_valid); end
    endtask

    initial begin
        test_reset;
        test_single_burst;
        test_round_robin;
        test_lock;
        test_backpressure;
        test_reset_mid_burst;
        test_random;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
